// File: rtl/coordinator_pkg.sv
// coordinator_pkg: shared FSM states, status codes and loader constants for the coordinator block.
package coordinator_pkg;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_PARAM = 2'd1,
    LOAD_IMG   = 2'd2,
    IMG_DONE   = 2'd3
  } state_e;
  localparam logic [3:0] STAT_IDLE  = 4'd0;
  localparam logic [3:0] STAT_PARAM = 4'd1;
  localparam logic [3:0] STAT_IMG   = 4'd2;
  localparam logic [3:0] STAT_DONE  = 4'd3;
  localparam int IMG_PERIOD_DEF = 34;
  localparam int HDR_BASE_HI    = 2;
  localparam int HDR_BASE_LO    = 3;
  localparam int RLE_MAX        = 32;
  function automatic logic [3:0] status_of(state_e s);
    return s == IDLE ? STAT_IDLE : s == LOAD_PARAM ? STAT_PARAM : s == LOAD_IMG ? STAT_IMG : STAT_DONE;
  endfunction
endpackage

// File: rtl/coordinator_ram.sv
// coordinator_ram: single-clock byte RAM with one write port and one registered read port (old data on collision).
module coordinator_ram
  import coordinator_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);
  logic [7:0] r_mem [2**ADDR_W];
  logic [7:0] r_rdata;
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  always_ff @(posedge i_clk)
    if (!i_rst_n) r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  assign o_rdata = r_rdata;
endmodule

// File: rtl/coordinator.sv
// coordinator: loads CNN parameter words or run-length compressed images into a byte RAM; host port access when idle.
// Optional registered host read port enabled by macro COORDINATOR_HOST_READ_EN.
module coordinator
  import coordinator_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] IMG_BASE   = 16'hC000,
  parameter int                IMG_PERIOD = IMG_PERIOD_DEF
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              interrupt,
  input  logic              load,
  input  logic              cnn,
  input  logic [15:0]       Din,
  output logic [3:0]        Dout,
  input  logic [ADDR_W-1:0] ramAddress,
  input  logic [7:0]        ramDataIn,
  output logic [7:0]        ramDataOut,
  input  logic              readSignal,
  input  logic              writeSignal
);
  localparam int PH_W = $clog2(IMG_PERIOD + 1);
  state_e            r_state;
  logic              r_prev_load;
  logic              r_closing;
  logic [ADDR_W-1:0] r_wptr;
  logic [15:0]       r_param_base;
  logic [15:0]       r_word;
  logic [PH_W-1:0]   r_phase;
  logic              w_rise, w_open, w_host_we, w_par_we, w_img_we, w_load_we, w_we, w_re, w_last;
  logic [7:0]        w_n, w_rdata, w_wdata;
  logic [ADDR_W-1:0] w_waddr;
  assign w_rise    = load & ~r_prev_load;
  assign w_open    = r_state == IDLE || r_state == IMG_DONE;
  assign w_host_we = writeSignal & w_open & ~interrupt & RST;
  // run length is capped so a word never spills past its slot
  assign w_n       = r_word[7:0] > 8'(RLE_MAX) ? 8'(RLE_MAX) : r_word[7:0];
  assign w_par_we  = r_state == LOAD_PARAM && load;
  assign w_img_we  = r_state == LOAD_IMG && r_phase != '0 && 8'(r_phase) <= w_n;
  assign w_load_we = (w_par_we | w_img_we) & ~interrupt & RST;
  assign w_last    = r_phase == PH_W'(IMG_PERIOD - 1);
  assign w_we      = w_host_we | w_load_we;
  assign w_waddr   = w_host_we ? ramAddress
                   : r_wptr + ADDR_W'(r_state == LOAD_PARAM && r_phase[0]);
  assign w_wdata   = w_host_we ? ramDataIn
                   : r_state == LOAD_PARAM ? (r_phase[0] ? Din[7:0] : Din[15:8]) : r_word[15:8];
  assign Dout      = status_of(r_state);
`ifdef COORDINATOR_HOST_READ_EN
  assign w_re       = readSignal & ~interrupt;
  assign ramDataOut = w_rdata;
`else
  // read path disabled; terms kept so every port and RAM output stays referenced
  assign w_re       = readSignal & 1'b0;
  assign ramDataOut = w_rdata & 8'h00;
`endif
  always_ff @(posedge clk)
    if (!RST) begin
      r_state      <= IDLE;
      r_prev_load  <= 1'b0;
      r_closing    <= 1'b0;
      r_wptr       <= '0;
      r_param_base <= '0;
      r_word       <= '0;
      r_phase      <= '0;
    end else begin
      r_prev_load <= load;
      if (w_host_we && ramAddress == ADDR_W'(HDR_BASE_HI)) r_param_base[15:8] <= ramDataIn;
      if (w_host_we && ramAddress == ADDR_W'(HDR_BASE_LO)) r_param_base[7:0] <= ramDataIn;
      if (interrupt) begin
        r_state   <= IDLE;
        r_phase   <= '0;
        r_closing <= 1'b0;
      end else begin
        case (r_state)
          IDLE, IMG_DONE:
            if (w_rise) begin
              r_state   <= cnn ? LOAD_PARAM : LOAD_IMG;
              r_wptr    <= cnn ? ADDR_W'(r_param_base) : IMG_BASE;
              r_phase   <= '0;
              r_closing <= 1'b0;
            end
          LOAD_PARAM:
            if (!load) begin
              r_state <= IDLE;
              r_phase <= '0;
            end else begin
              r_phase <= PH_W'(~r_phase[0]);
              if (r_phase[0]) r_wptr <= r_wptr + ADDR_W'(2);
            end
          LOAD_IMG: begin
            if (r_phase == '0) r_word <= Din;
            if (w_img_we) r_wptr <= r_wptr + ADDR_W'(1);
            if (!load) r_closing <= 1'b1;
            r_phase <= w_last ? '0 : r_phase + PH_W'(1);
            if (w_last && (r_closing || !load)) r_state <= IMG_DONE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  coordinator_ram #(.ADDR_W(ADDR_W)) u_ram (
    .i_clk  (clk),
    .i_rst_n(RST),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_re   (w_re),
    .i_raddr(ramAddress),
    .o_rdata(w_rdata)
  );
endmodule

// File: tb/tb_coordinator.sv
// tb_coordinator: randomized self-checking bench for coordinator against a byte-level memory model.
module tb_coordinator;
  localparam int          AW = 16;
  localparam logic [15:0] IB = 16'hC000;
  localparam int          P  = 34;
`ifdef COORDINATOR_HOST_READ_EN
  localparam bit RD_EN = 1'b1;
`else
  localparam bit RD_EN = 1'b0;
`endif
  logic        clk = 0, RST = 0, interrupt = 0, load = 0, cnn = 0, readSignal = 0, writeSignal = 0;
  logic [15:0] Din = 0, ramAddress = 0;
  logic [7:0]  ramDataIn = 0, ramDataOut, last_rd = 0, old;
  logic [3:0]  Dout;
  logic [7:0]  ref_mem [int];
  logic [15:0] pb = 0, ptr, w;
  logic [15:0] wq [$];
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  coordinator #(.ADDR_W(AW), .IMG_BASE(IB), .IMG_PERIOD(P)) dut (
    .clk(clk), .RST(RST), .interrupt(interrupt), .load(load), .cnn(cnn), .Din(Din), .Dout(Dout),
    .ramAddress(ramAddress), .ramDataIn(ramDataIn), .ramDataOut(ramDataOut),
    .readSignal(readSignal), .writeSignal(writeSignal)
  );
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic host_wr(input logic [15:0] a, input logic [7:0] d);
    ramAddress = a; ramDataIn = d; writeSignal = 1; tick(); writeSignal = 0;
    ref_mem[int'(a)] = d;
    if (a == 2) pb[15:8] = d;
    if (a == 3) pb[7:0] = d;
  endtask
  task automatic host_rd(input string tag, input logic [15:0] a);
    ramAddress = a; readSignal = 1; tick(); readSignal = 0;
    last_rd = RD_EN ? ref_mem[int'(a)] : 8'h00;
    chk(tag, ramDataOut, last_rd);
  endtask
  task automatic mem_at(input string tag, input logic [15:0] a);
    chk(tag, dut.u_ram.r_mem[a], ref_mem[int'(a)]);
  endtask
  task automatic check_mem(input string tag);
    foreach (ref_mem[a]) chk(tag, dut.u_ram.r_mem[16'(a)], ref_mem[a]);
  endtask
  // a parameter word lands as two bytes, high first, at base + 2*index
  task automatic param_load(input int nw);
    logic [15:0] base = pb;
    cnn = 1; load = 1; tick();
    chk("param_dout", Dout, 4'd1);
    for (int i = 0; i < nw; i++) begin
      Din = 16'($urandom);
      tick(2);
      ref_mem[int'(16'(base + 16'(2 * i)))] = Din[15:8];
      ref_mem[int'(16'(base + 16'(2 * i + 1)))] = Din[7:0];
    end
    load = 0; tick();
    chk("param_end", Dout, 4'd0);
  endtask
  task automatic img_model(input logic [15:0] wd);
    int n = wd[7:0] > 32 ? 32 : int'(wd[7:0]);
    for (int j = 0; j < n; j++) begin
      ref_mem[int'(ptr)] = wd[15:8];
      ptr++;
    end
  endtask
  task automatic img_load();
    cnn = 0; load = 1; ptr = IB; tick();
    chk("img_dout", Dout, 4'd2);
    for (int k = 0; k < wq.size(); k++) begin
      Din = wq[k];
      if (k == wq.size() - 1) begin
        tick(10); load = 0; tick();
        chk("img_closing", Dout, 4'd2);
        tick(23);
      end else tick(P);
      img_model(wq[k]);
    end
    chk("img_done", Dout, 4'd3);
  endtask
  initial begin
    tick(2);
    chk("rst_dout", Dout, 4'd0);
    chk("rst_rd", ramDataOut, 8'h00);
    RST = 1; tick();
    for (int a = 0; a < 16; a++) host_wr(16'(a), 8'($urandom));
    for (int a = 0; a < 4; a++) host_wr(16'hFFFC + 16'(a), 8'($urandom));
    for (int i = 0; i < 80; i++) host_wr(IB + 16'(i), 8'($urandom));
    host_wr(2, 8'h00); host_wr(3, 8'h0B);
    cnn = 1; load = 1; tick();
    Din = 16'hA5C3; tick(2);
    ref_mem[11] = 8'hA5; ref_mem[12] = 8'hC3;
    mem_at("p11", 11); mem_at("p12", 12);
    chk("p_dout", Dout, 4'd1);
    load = 0; tick();
    chk("p_idle", Dout, 4'd0);
    host_rd("rd11", 11);
    tick();
    chk("rd_hold", ramDataOut, last_rd);
    repeat (3) begin
      host_wr(2, 8'($urandom)); host_wr(3, 8'($urandom));
      param_load(1 + int'($urandom % 4));
    end
    host_wr(2, 8'hFF); host_wr(3, 8'hFE);
    param_load(2);
    mem_at("wrap0", 16'h0000); mem_at("wrap1", 16'h0001);
    cnn = 0; load = 1; tick();
    chk("i_dout", Dout, 4'd2);
    Din = 16'h7F03; tick();
    old = ref_mem[int'(IB)];
    ramAddress = IB; readSignal = 1; tick(); readSignal = 0;
    chk("rd_old", ramDataOut, RD_EN ? old : 8'h00);
    tick(P - 2);
    ptr = IB; img_model(16'h7F03);
    mem_at("i_b2", IB + 16'd2); mem_at("i_b3", IB + 16'd3);
    w = {8'($urandom), 8'd5}; Din = w;
    tick(10); load = 0; tick();
    chk("i_closing", Dout, 4'd2);
    tick(P - 11);
    img_model(w);
    chk("i_done", Dout, 4'd3);
    mem_at("i_b7", IB + 16'd7); mem_at("i_b8", IB + 16'd8);
    host_wr(IB + 16'd70, 8'($urandom));
    mem_at("done_wr", IB + 16'd70);
    wq = '{{8'($urandom), 8'd40}, {8'($urandom), 8'd0}, {8'($urandom), 8'd3}};
    img_load();
    mem_at("c40_last", IB + 16'd31); mem_at("c40_next", IB + 16'd32); mem_at("c3_end", IB + 16'd35);
    repeat (2) begin
      wq = '{{8'($urandom), 8'($urandom_range(0, 45))}, {8'($urandom), 8'($urandom_range(0, 45))}};
      img_load();
    end
    w = {8'($urandom), 8'd20};
    cnn = 0; load = 1; tick();
    Din = w; ramAddress = 5; ramDataIn = ~ref_mem[5]; writeSignal = 1; tick(); writeSignal = 0;
    mem_at("blocked_wr", 5);
    tick(7);
    interrupt = 1; tick(); interrupt = 0;
    chk("int_dout", Dout, 4'd0);
    for (int j = 0; j < 7; j++) ref_mem[int'(IB) + j] = w[15:8];
    tick(30);
    chk("int_stay", Dout, 4'd0);
    mem_at("int_b6", IB + 16'd6); mem_at("int_b7", IB + 16'd7);
    load = 0; tick();
    param_load(1);
    host_wr(2, 8'($urandom)); host_wr(3, 8'($urandom));
    cnn = 1; load = 1; tick();
    Din = 16'($urandom); tick(2);
    ref_mem[int'(pb)] = Din[15:8]; ref_mem[int'(16'(pb + 16'd1))] = Din[7:0];
    Din = 16'($urandom); tick();
    ref_mem[int'(16'(pb + 16'd2))] = Din[15:8];
    RST = 0; tick();
    chk("rst_mid_dout", Dout, 4'd0);
    chk("rst_mid_rd", ramDataOut, 8'h00);
    RST = 1; load = 0; pb = 0; tick();
    param_load(1);
    check_mem("mem");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
